// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU command path.
package alu_pkg;

    localparam int unsigned OPND_W = 5;
    localparam int unsigned RES_W  = 6;
    localparam int unsigned AOP_W  = 3;
    localparam int unsigned BOP_W  = 2;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              a_en;
        logic [AOP_W-1:0]  a_op;
        logic              b_en;
        logic [BOP_W-1:0]  b_op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO; an extra pointer bit separates full from empty.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers tagged ALU commands, issues one per cycle and returns tagged results
// after the fixed ALU latency.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [OPND_W-1:0]                cmd_a,
    input  logic [OPND_W-1:0]                cmd_b,
    input  logic                             cmd_a_en,
    input  logic                             cmd_b_en,
    input  logic [AOP_W-1:0]                 cmd_a_op,
    input  logic [BOP_W-1:0]                 cmd_b_op,
    input  logic [TAG_W-1:0]                 cmd_tag,
    input  logic                             flush,
    output logic                             ALU_en,
    output logic [OPND_W-1:0]                A,
    output logic [OPND_W-1:0]                B,
    output logic                             a_en,
    output logic [AOP_W-1:0]                 a_op,
    output logic                             b_en,
    output logic [BOP_W-1:0]                 b_op,
    input  logic                             C_en,
    input  logic [RES_W-1:0]                 C,
    output logic                             res_valid,
    output logic [RES_W-1:0]                 res_data,
    output logic [TAG_W-1:0]                 res_tag,
    output logic                             res_err,
    output logic [$clog2(ALU_LAT+2)-1:0]     inflight
);
    localparam int unsigned INF_W = $clog2(ALU_LAT + 2);
    localparam int unsigned CW    = $bits(alu_cmd_t);
    localparam int unsigned FW    = CW + TAG_W;

    seq_state_t       state;
    seq_state_t       state_next;
    alu_cmd_t         in_cmd;
    alu_cmd_t         head_cmd;
    alu_cmd_t         issue_cmd;
    alu_cmd_t         drive_cmd;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] issue_tag;
    logic [FW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             issue;
    logic             push;
    logic             pop;
    logic [ALU_LAT:0] pipe_vld;
    logic [TAG_W-1:0] pipe_tag [ALU_LAT+1];
    logic             fin_vld;
    logic [TAG_W-1:0] fin_tag;

    assign in_cmd    = '{a: cmd_a, b: cmd_b, a_en: cmd_a_en, a_op: cmd_a_op,
                         b_en: cmd_b_en, b_op: cmd_b_op};
    assign head_cmd  = alu_cmd_t'(fifo_rdata[CW-1:0]);
    assign head_tag  = fifo_rdata[FW-1:CW];
    assign fin_vld   = pipe_vld[ALU_LAT];
    assign fin_tag   = pipe_tag[ALU_LAT];
    assign drive_cmd = issue ? issue_cmd : '0;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd_tag, in_cmd}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // An empty FIFO is bypassed so an accepted command reaches the ALU next cycle.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_cmd  = in_cmd;
        issue_tag  = cmd_tag;
        cmd_ready  = !fifo_full && (state != ST_DRAIN) && !flush;
        accept     = cmd_valid && cmd_ready;

        if (!fifo_empty && !flush) begin
            pop       = 1'b1;
            issue     = 1'b1;
            issue_cmd = head_cmd;
            issue_tag = head_tag;
            push      = accept;
        end else if (accept) begin
            issue = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                if (flush)       state_next = ST_DRAIN;
                else if (accept) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (flush)
                    state_next = ST_DRAIN;
                else if (fifo_empty && (inflight == '0) && !accept)
                    state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if ((inflight == '0) && !flush) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_en <= 1'b0;
            A      <= '0;
            B      <= '0;
            a_en   <= 1'b0;
            a_op   <= '0;
            b_en   <= 1'b0;
            b_op   <= '0;
        end else begin
            ALU_en <= issue;
            A      <= drive_cmd.a;
            B      <= drive_cmd.b;
            a_en   <= drive_cmd.a_en;
            a_op   <= drive_cmd.a_op;
            b_en   <= drive_cmd.b_en;
            b_op   <= drive_cmd.b_op;
        end
    end

    // Tag pipeline lines up each issued tag with the cycle its result appears on C.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < ALU_LAT + 1; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld    <= {pipe_vld[ALU_LAT-1:0], issue};
            pipe_tag[0] <= issue_tag;
            for (int unsigned i = 1; i < ALU_LAT + 1; i++) pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
            inflight  <= '0;
        end else begin
            res_valid <= fin_vld;
            res_data  <= fin_vld ? C : '0;
            res_tag   <= fin_vld ? fin_tag : '0;
            res_err   <= fin_vld && !C_en;
            inflight  <= inflight + INF_W'(issue) - INF_W'(fin_vld);
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a stand-in two-cycle ALU model.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_a = '0, cmd_b = '0;
    logic       cmd_a_en = 1'b0, cmd_b_en = 1'b0;
    logic [2:0] cmd_a_op = '0;
    logic [1:0] cmd_b_op = '0;
    logic [1:0] cmd_tag = '0;
    logic       flush = 1'b0;
    logic       ALU_en;
    logic [4:0] A, B;
    logic       a_en, b_en;
    logic [2:0] a_op;
    logic [1:0] b_op;
    logic       C_en;
    logic [5:0] C;
    logic       res_valid;
    logic [5:0] res_data;
    logic [1:0] res_tag;
    logic       res_err;
    logic [1:0] inflight;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int max_infl = 0;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       a_en;
        logic [2:0] a_op;
        logic       b_en;
        logic [1:0] b_op;
        logic [1:0] tag;
        logic [5:0] exp_data;
        logic       exp_err;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [5:0] data;
        logic [1:0] tag;
        logic       err;
    } res_t;

    res_t rq[$];

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(2), .ALU_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_a_en(cmd_a_en), .cmd_b_en(cmd_b_en),
        .cmd_a_op(cmd_a_op), .cmd_b_op(cmd_b_op), .cmd_tag(cmd_tag), .flush(flush),
        .ALU_en(ALU_en), .A(A), .B(B), .a_en(a_en), .a_op(a_op), .b_en(b_en), .b_op(b_op),
        .C_en(C_en), .C(C),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .res_err(res_err),
        .inflight(inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: add for a_op 0, invert A for b_op 2; operands 15,15 fault C_en.
    function automatic logic [5:0] alu_fn(input logic [4:0] a, input logic [4:0] b,
                                          input logic ae, input logic [2:0] aop,
                                          input logic be, input logic [1:0] bop);
        if (ae && aop == 3'd0) return {a[4], a} + {b[4], b};
        if (be && bop == 2'd2) return ~{a[4], a};
        return 6'd0;
    endfunction

    logic       s1_v = 1'b0, s2_v = 1'b0, s1_f = 1'b0, s2_f = 1'b0;
    logic [5:0] s1_c = '0, s2_c = '0;
    always @(posedge clk) begin
        s1_v <= ALU_en;
        s1_c <= alu_fn(A, B, a_en, a_op, b_en, b_op);
        s1_f <= (A == 5'd15) && (B == 5'd15);
        s2_v <= s1_v;
        s2_c <= s1_c;
        s2_f <= s1_f;
    end
    assign C    = s2_c;
    assign C_en = s2_v && !s2_f;

    always @(negedge clk) begin
        if (res_valid) rq.push_back('{cyc, res_data, res_tag, res_err});
        if (int'(inflight) > max_infl) max_infl = int'(inflight);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_cmd(input vec_t v);
        cmd_valid = 1'b1;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_a_en  = v.a_en;
        cmd_a_op  = v.a_op;
        cmd_b_en  = v.b_en;
        cmd_b_op  = v.b_op;
        cmd_tag   = v.tag;
    endtask

    vec_t vecs[6];
    vec_t burst[4];
    vec_t fl[3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{5'd3,     5'd4,     1'b1, 3'd0, 1'b0, 2'd0, 2'd1, 6'd7,      1'b0};
        vecs[1] = '{5'b10000, 5'b10000, 1'b1, 3'd0, 1'b0, 2'd0, 2'd2, 6'b100000, 1'b0};
        vecs[2] = '{5'd0,     5'd5,     1'b1, 3'd1, 1'b1, 2'd2, 2'd3, 6'b111111, 1'b0};
        vecs[3] = '{5'd15,    5'd15,    1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 6'd30,     1'b1};
        vecs[4] = '{5'b11101, 5'd2,     1'b1, 3'd0, 1'b0, 2'd0, 2'd2, 6'b111111, 1'b0};
        vecs[5] = '{5'd7,     5'b11000, 1'b0, 3'd5, 1'b1, 2'd1, 2'd1, 6'd0,      1'b0};

        burst[0] = '{5'd1,     5'd2,     1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 6'd3,      1'b0};
        burst[1] = '{5'd15,    5'd15,    1'b1, 3'd0, 1'b0, 2'd0, 2'd1, 6'd30,     1'b1};
        burst[2] = '{5'b11011, 5'b11010, 1'b1, 3'd0, 1'b0, 2'd0, 2'd2, 6'b110101, 1'b0};
        burst[3] = '{5'd4,     5'd9,     1'b1, 3'd0, 1'b0, 2'd0, 2'd3, 6'd13,     1'b0};

        fl[0] = '{5'd1, 5'd1, 1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 6'd2, 1'b0};
        fl[1] = '{5'd2, 5'd2, 1'b1, 3'd0, 1'b0, 2'd0, 2'd1, 6'd4, 1'b0};
        fl[2] = '{5'd3, 5'd3, 1'b1, 3'd0, 1'b0, 2'd0, 2'd2, 6'd6, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu_en", ALU_en, 0);
        check("rst_A", A, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_inflight", inflight, 0);
        rst = 1'b0;

        // Single-command vectors: issue at t+1, result at t+4
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("vec_ready", cmd_ready, 1);
            set_cmd(vecs[i]);
            @(negedge clk);
            cmd_valid = 1'b0;
            check("vec_alu_en", ALU_en, 1);
            check("vec_A", A, vecs[i].a);
            check("vec_B", B, vecs[i].b);
            check("vec_a_en", a_en, vecs[i].a_en);
            check("vec_a_op", a_op, vecs[i].a_op);
            check("vec_b_en", b_en, vecs[i].b_en);
            check("vec_b_op", b_op, vecs[i].b_op);
            check("vec_inflight1", inflight, 1);
            check("vec_res_early", res_valid, 0);
            @(negedge clk);
            check("vec_alu_en_off", ALU_en, 0);
            check("vec_A_off", A, 0);
            @(negedge clk);
            check("vec_res_t3", res_valid, 0);
            @(negedge clk);
            check("vec_res_valid", res_valid, 1);
            check("vec_res_data", res_data, vecs[i].exp_data);
            check("vec_res_tag", res_tag, vecs[i].tag);
            check("vec_res_err", res_err, vecs[i].exp_err);
            check("vec_inflight0", inflight, 0);
            @(negedge clk);
            check("vec_res_done", res_valid, 0);
        end

        // Back-to-back burst, one faulting op in the middle
        rq.delete();
        max_infl = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("burst_ready", cmd_ready, 1);
            set_cmd(burst[k]);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("burst_count", rq.size(), 4);
        for (int k = 0; k < 4 && k < rq.size(); k++) begin
            check("burst_tag", rq[k].tag, burst[k].tag);
            check("burst_data", rq[k].data, burst[k].exp_data);
            check("burst_err", rq[k].err, burst[k].exp_err);
            check("burst_consecutive", rq[k].cyc - rq[0].cyc, k);
        end
        check("burst_max_inflight", max_infl, 3);

        // Flush while the third command is offered
        rq.delete();
        @(negedge clk);
        set_cmd(fl[0]);
        @(negedge clk);
        set_cmd(fl[1]);
        @(negedge clk);
        set_cmd(fl[2]);
        flush = 1'b1;
        #1;
        check("flush_ready", cmd_ready, 0);
        check("flush_second_issue", ALU_en, 1);
        @(negedge clk);
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("drain_alu_en", ALU_en, 0);
        check("drain_ready0", cmd_ready, 0);
        @(negedge clk);
        check("drain_ready1", cmd_ready, 0);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("drain_exit_cycles", w, 2);
        repeat (3) @(negedge clk);
        #1;
        check("flush_count", rq.size(), 2);
        for (int k = 0; k < 2 && k < rq.size(); k++) begin
            check("flush_tag", rq[k].tag, fl[k].tag);
            check("flush_data", rq[k].data, fl[k].exp_data);
        end

        // Reset with two commands in flight
        rq.delete();
        @(negedge clk);
        set_cmd(fl[0]);
        @(negedge clk);
        set_cmd(fl[1]);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_ready", cmd_ready, 1);
        check("mrst_inflight", inflight, 0);
        check("mrst_alu_en", ALU_en, 0);
        check("mrst_res_valid", res_valid, 0);
        repeat (6) @(negedge clk);
        #1;
        check("mrst_no_results", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
